pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined successor to the single-cycle 32-bit right shifter.
- Supports logical left and right shifts, arithmetic right shift, rotates, and right shift with an explicit fill bit.
- Uses one register stage per shift bit, so the design closes timing at WIDTH=64.
- Valid/ready handshakes on input and output; sits between the ALU operand muxes and the writeback result mux.

Parameters:
- WIDTH, 32, data width; must be a power of 2, at least 8.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the input beat this cycle
- in_data  input  WIDTH  operand to shift
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  3  operation code (see Behaviour)
- in_fill  input  1  fill bit for op SRF
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- busy  output  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset clears all stage valid bits and data registers. Outputs after reset: out_valid=0, out_data=0, busy=0. in_ready=1 once reset deasserts.
- Operation codes:
  - 000 SLL: shift left, zero fill.
  - 001 SRL: shift right, zero fill.
  - 010 SRA: shift right, fill with in_data[WIDTH-1].
  - 011 ROR: rotate right.
  - 100 ROL: rotate left.
  - 101 SRF: shift right, fill with in_fill.
  - 110 and 111: pass-through, out_data = in_data.
- Pipeline structure:
  - Stages 0..SHAMT_W-1. Stage k conditionally shifts by 2^k when shamt bit k is set.
  - Each stage registers data, remaining shamt bits, op, fill bit and valid.
  - The fill bit is resolved at acceptance: SRA captures the sign bit, SRL and SLL capture 0, SRF captures in_fill.
- Latency: exactly SHAMT_W cycles from the accepting edge (in_valid & in_ready) to out_valid, provided there is no backpressure.
- Throughput: one beat per cycle.
- Flow control, per stage with bubble collapse:
  - The last stage can load when it is empty or (out_valid & out_ready).
  - Stage k can load when it is empty or stage k+1 can load.
  - in_ready = "stage 0 can load".
  - A stage that cannot load holds its contents unchanged.
- Output holding: while out_valid=1 and out_ready=0, out_data and out_valid stay stable until the handshake completes.
- Shift amount zero: data passes unchanged for every op. Latency is still SHAMT_W.
- Maximum shift amount WIDTH-1:
  - SLL leaves only bit 0 of the input, moved to the MSB.
  - SRA produces all copies of the sign bit.
  - Rotates wrap modulo WIDTH.
- Simultaneous events: when out_valid & out_ready & in_valid are all high with the pipe full, the block accepts a new beat in the same cycle; there is no lost cycle.
- Input sampling: in_data, in_shamt, in_op and in_fill are sampled only on the accepting edge. Changes while in_ready=0 have no effect.
- Reset mid-operation: in-flight beats are discarded, out_valid drops asynchronously, and no partial result is emitted.
- busy is asserted whenever any stage holds a valid beat.

Test Plan:
- WIDTH=32, out_ready=1. SRA of 0x80000010 by 4 -> out_data=0xF8000001 after exactly 5 cycles. SRL of the same value -> 0x08000001.
- SRF, in_fill=1, data 0x0000000F, shamt 8 -> 0xFF000000. ROR of 0x12345678 by 8 -> 0x78123456. ROL of 0x12345678 by 4 -> 0x23456781.
- SLL of 0x00000001 by 31 -> 0x80000000. Any op with shamt 0 returns the input unchanged. Op 111 -> pass-through.
- Backpressure:
  - Stream 8 back-to-back beats with out_ready=0 for 10 cycles.
  - in_ready drops after 5 accepted beats.
  - out_data holds the first result stable throughout.
  - On releasing out_ready, all 8 results emerge in order, one per cycle, with no loss or duplication.
- Bubble collapse: send beat A, idle 2 cycles, send beat B, while out_ready=0. Both beats are accepted. busy=1 until both results have drained.
- Assert reset while 3 beats are in flight -> out_valid=0 and busy=0 immediately. After release, no stale result appears, and a new beat returns the correct value with a 5-cycle latency.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready at both ends.
// Stage k applies a 2^k step when its shamt bit is set; empty stages collapse under backpressure.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  input  logic               in_fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [2:0] {
    OpSll   = 3'b000,
    OpSrl   = 3'b001,
    OpSra   = 3'b010,
    OpRor   = 3'b011,
    OpRol   = 3'b100,
    OpSrf   = 3'b101,
    OpPass0 = 3'b110,
    OpPass1 = 3'b111
  } op_e;

  localparam int unsigned Last = SHAMT_W - 1;

  if (SHAMT_W != $clog2(WIDTH) || WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_params
    $error("pipelined_barrel_shifter: WIDTH must be a power of 2 >= 8 and SHAMT_W = log2(WIDTH)");
  end

  // Stage registers
  logic [SHAMT_W-1:0] valid_q;
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  op_e                op_q    [SHAMT_W];
  logic               fill_q  [SHAMT_W];

  // What each stage would capture this cycle
  logic [SHAMT_W-1:0] src_valid;
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  op_e                src_op    [SHAMT_W];
  logic               src_fill  [SHAMT_W];
  logic [WIDTH-1:0]   shift_d   [SHAMT_W];
  logic [SHAMT_W-1:0] load;

  // Right shifts share one path: the fill bit already encodes SRL/SRA/SRF.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input op_e              op,
                                                   input logic             fill,
                                                   input logic             en,
                                                   input int unsigned      amt);
    logic [WIDTH-1:0] fill_mask;
    fill_mask   = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
    stage_shift = d;
    if (en) begin
      case (op)
        OpSll:               stage_shift = d << amt;
        OpSrl, OpSra, OpSrf: stage_shift = (d >> amt) | fill_mask;
        OpRor:               stage_shift = (d >> amt) | (d << (WIDTH - amt));
        OpRol:               stage_shift = (d << amt) | (d >> (WIDTH - amt));
        default:             stage_shift = d;
      endcase
    end
  endfunction

  // Ready ripples back from the consumer; an empty stage can always take its predecessor.
  always_comb begin : flow_ctrl
    logic chain;
    load       = '0;
    chain      = ~valid_q[Last] | out_ready;
    load[Last] = chain;
    for (int k = int'(SHAMT_W) - 2; k >= 0; k--) begin
      chain   = ~valid_q[k] | chain;
      load[k] = chain;
    end
  end

  always_comb begin : stage_sources
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = op_e'(in_op);
    case (op_e'(in_op))
      OpSra:   src_fill[0] = in_data[WIDTH-1];
      OpSrf:   src_fill[0] = in_fill;
      default: src_fill[0] = 1'b0;
    endcase
    for (int k = 1; k < int'(SHAMT_W); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_fill[k]  = fill_q[k-1];
    end
  end

  always_comb begin : stage_shifters
    for (int k = 0; k < int'(SHAMT_W); k++) begin
      shift_d[k] = stage_shift(src_data[k], src_op[k], src_fill[k], src_shamt[k][k],
                               32'd1 << k);
    end
  end

  // Payload only moves with a valid beat so bubbles do not toggle the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < int'(SHAMT_W); k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= OpSll;
        fill_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < int'(SHAMT_W); k++) begin
        if (load[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k]  <= shift_d[k];
            shamt_q[k] <= src_shamt[k];
            op_q[k]    <= src_op[k];
            fill_q[k]  <= src_fill[k];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[Last];
  assign out_data  = data_q[Last];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32): directed vectors, random
// traffic against an arithmetic reference model, backpressure, bubble collapse, mid-flight reset.
module tb_pipelined_barrel_shifter;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic [SW-1:0] in_shamt  = '0;
  logic [2:0]    in_op     = '0;
  logic          in_fill   = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s,
                                             input logic [2:0] op, input logic fill);
    logic [W-1:0]        ones;
    logic signed [W-1:0] sd;
    ones = '1;
    sd   = d;
    case (op)
      3'd0:    return d << s;
      3'd1:    return d >> s;
      3'd2:    return sd >>> s;
      3'd3:    return (d >> s) | (d << (W - s));
      3'd4:    return (d << s) | (d >> (W - s));
      3'd5:    return (d >> s) | (fill ? ~(ones >> s) : '0);
      default: return d;
    endcase
  endfunction

  task automatic drive_random_beat();
    int r;
    r        = $urandom_range(0, 5);
    in_data  = $urandom;
    in_shamt = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
    in_op    = 3'($urandom_range(0, 7));
    in_fill  = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  // Latency counts clock edges including the accepting one.
  task automatic test_directed();
    logic [W-1:0]  dd [16];
    logic [SW-1:0] ds [16];
    logic [2:0]    dop[16];
    logic          df [16];
    logic [W-1:0]  de [16];
    dd  = '{32'h80000010, 32'h80000010, 32'h0000000F, 32'h12345678, 32'h12345678, 32'h00000001,
            32'h80000000, 32'h00000001, 32'hA5A51234, 32'hA5A51234, 32'h80000010, 32'hFFFFFFFE,
            32'hF0000000, 32'h12345678, 32'h80000001, 32'h80000000};
    ds  = '{5'd4, 5'd4, 5'd8, 5'd8, 5'd4, 5'd31, 5'd31, 5'd31, 5'd7, 5'd7, 5'd0, 5'd31,
            5'd4, 5'd0, 5'd31, 5'd31};
    dop = '{3'd2, 3'd1, 3'd5, 3'd3, 3'd4, 3'd0, 3'd2, 3'd3, 3'd7, 3'd6, 3'd2, 3'd0,
            3'd5, 3'd3, 3'd4, 3'd5};
    df  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
            1'b0, 1'b1, 1'b0, 1'b1};
    de  = '{32'hF8000001, 32'h08000001, 32'hFF000000, 32'h78123456, 32'h23456781, 32'h80000000,
            32'hFFFFFFFF, 32'h00000002, 32'hA5A51234, 32'hA5A51234, 32'h80000010, 32'h00000000,
            32'h0F000000, 32'h12345678, 32'hC0000000, 32'hFFFFFFFF};
    for (int i = 0; i < 16; i++) begin
      int lat;
      bit seen;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = dd[i];
      in_shamt  = ds[i];
      in_op     = dop[i];
      in_fill   = df[i];
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drive_random_beat();
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= 20) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen = 1'b1;
        else begin
          @(posedge clk);
          lat++;
        end
      end
      checks++;
      if (!seen || lat != SW) begin
        failures++; $display("FAIL dir%0d_latency got=%0d seen=%b want=%0d", i, lat, seen, SW);
      end
      checks++;
      if (out_data !== de[i]) begin
        failures++; $display("FAIL dir%0d_data got=%h want=%h", i, out_data, de[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    logic [W-1:0] e;
    bit           hold_pending;
    hold_pending = 1'b0;
    held         = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, busy, exp_q.size() != 0);
      end
      if (hold_pending) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h", c, out_valid, out_data, held);
        end
      end
      if (c < 440) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      drive_random_beat();
      #1;
      hold_pending = (out_valid === 1'b1) && !out_ready;
      held         = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious cyc=%0d got=%h want=no_output", c, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", c, out_data, e);
          end
        end
      end
      if (in_valid && in_ready === 1'b1)
        exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_op, in_fill));
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  bd[8];
    logic [W-1:0]  be[8];
    logic [SW-1:0] bs[8];
    logic [2:0]    bo[8];
    logic          bf[8];
    int acc, ndel, nval;
    for (int i = 0; i < 8; i++) begin
      bd[i] = $urandom;
      bs[i] = 5'($urandom);
      bo[i] = 3'($urandom_range(0, 7));
      bf[i] = 1'($urandom);
      be[i] = ref_shift(bd[i], int'(bs[i]), bo[i], bf[i]);
    end
    acc  = 0;
    ndel = 0;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid === 1'b1) begin
        nval++;
        checks++;
        if (out_data !== be[0]) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c, out_data, be[0]);
        end
      end
      in_valid = (acc < 8);
      if (acc < 8) begin
        in_data = bd[acc]; in_shamt = bs[acc]; in_op = bo[acc]; in_fill = bf[acc];
      end
      #1;
      if (in_valid && in_ready === 1'b1) acc++;
    end
    @(negedge clk);
    checks++;
    if (acc != 5 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_fill got=%0d/%b want=5/0", acc, in_ready);
    end
    checks++;
    if (nval != 5 || out_valid !== 1'b1 || out_data !== be[0]) begin
      failures++;
      $display("FAIL bp_first got=%0d/%b/%h want=5/1/%h", nval, out_valid, out_data, be[0]);
    end
    for (int c = 0; c < 30 && ndel < 8; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (acc < 8);
      if (acc < 8) begin
        in_data = bd[acc]; in_shamt = bs[acc]; in_op = bo[acc]; in_fill = bf[acc];
      end
      out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== be[ndel] || c != ndel) begin
          failures++;
          $display("FAIL bp_out%0d got=%h@%0d want=%h@%0d", ndel, out_data, c, be[ndel], ndel);
        end
        ndel++;
      end
      if (in_valid && in_ready === 1'b1) acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (ndel != 8 || acc != 8) begin
      failures++; $display("FAIL bp_count got=%0d/%0d want=8/8", ndel, acc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_drained_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_bubble();
    logic [W-1:0] ea, eb;
    int ndel;
    out_ready = 1'b0;
    @(negedge clk);
    drive_random_beat();
    in_valid = 1'b1;
    ea = ref_shift(in_data, int'(in_shamt), in_op, in_fill);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bub_accept_a got=%b want=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_random_beat();
    in_valid = 1'b1;
    eb = ref_shift(in_data, int'(in_shamt), in_op, in_fill);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bub_accept_b got=%b want=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL bub_busy_stall cyc=%0d got=%b want=1", c, busy);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== ea) begin
      failures++; $display("FAIL bub_head got=%b/%h want=1/%h", out_valid, out_data, ea);
    end
    ndel = 0;
    for (int c = 0; c < 10 && ndel < 2; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL bub_busy_drain cyc=%0d got=%b want=1", c, busy);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== (ndel == 0 ? ea : eb) || c != ndel) begin
          failures++;
          $display("FAIL bub_out%0d got=%h@%0d want=%h@%0d", ndel, out_data, c,
                   ndel == 0 ? ea : eb, ndel);
        end
        ndel++;
      end
    end
    @(negedge clk);
    checks++;
    if (ndel != 2 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bub_end got=%0d/%b/%b want=2/0/0", ndel, busy, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] e;
    int  w, lat;
    bit  seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random_beat();
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL rst_accept%0d got=%b want=1", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_pre_valid got=%b want=1", out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL rst_async got=%b/%b/%h want=0/0/0", out_valid, busy, out_data);
    end
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rst_stale cyc=%0d got=%b want=0", c, out_valid);
      end
    end
    @(negedge clk);
    drive_random_beat();
    in_valid = 1'b1;
    e = ref_shift(in_data, int'(in_shamt), in_op, in_fill);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive_random_beat();
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || lat != SW || out_data !== e) begin
      failures++;
      $display("FAIL rst_new_beat got=%0d/%h want=%0d/%h", lat, out_data, SW, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_bubble();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
